// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the accelerator PLL domain: waits for stable lock, stretches reset, then releases.
// Optional software-triggered core reset is enabled by defining PLL_RST_SEQ_SW_RESET_EN.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       core_rst,
    output logic       core_rst_n,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] relock_count
);

    localparam int CNT_MAX = ((LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                              LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES) - 1;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } seqState_t;

    logic [SYNC_STAGES-1:0] lockedSync_q;
    logic                   lockedS;

    seqState_t              seqState_q, seqState_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             relockCount_q, relockCount_d;
    logic [7:0]             relockInc;
    logic                   coreRst_q;
    logic                   coreRstN_q;
    logic                   ready_q;

    // pll_locked is fully asynchronous and may glitch, so it only enters the FSM through this chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lockedSync_q <= '0;
        end else begin
            lockedSync_q <= {lockedSync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lockedS   = lockedSync_q[SYNC_STAGES-1];
    assign relockInc = (relockCount_q == 8'hFF) ? relockCount_q : relockCount_q + 8'd1;

`ifndef PLL_RST_SEQ_SW_RESET_EN
    logic unusedSwReset;
    assign unusedSwReset = sw_reset_req;
`endif

    // Lock loss is tested first in every locked state so it beats completion and software reset
    always_comb begin
        seqState_d    = seqState_q;
        cnt_d         = cnt_q;
        relockCount_d = relockCount_q;
        case (seqState_q)
            WAIT_LOCK: begin
                if (lockedS) begin
                    seqState_d = STABLE;
                    cnt_d      = '0;
                end
            end
            STABLE: begin
                if (!lockedS) begin
                    seqState_d    = WAIT_LOCK;
                    relockCount_d = relockInc;
                end else if (cnt_q == STABLE_LAST) begin
                    seqState_d = HOLD;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!lockedS) begin
                    seqState_d    = WAIT_LOCK;
                    relockCount_d = relockInc;
`ifdef PLL_RST_SEQ_SW_RESET_EN
                end else if (sw_reset_req) begin
                    cnt_d = '0;
`endif
                end else if (cnt_q == HOLD_LAST) begin
                    seqState_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lockedS) begin
                    seqState_d    = WAIT_LOCK;
                    relockCount_d = relockInc;
`ifdef PLL_RST_SEQ_SW_RESET_EN
                end else if (sw_reset_req) begin
                    seqState_d = HOLD;
                    cnt_d      = '0;
`endif
                end
            end
            default: begin
                seqState_d = WAIT_LOCK;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seqState_q    <= WAIT_LOCK;
            cnt_q         <= '0;
            relockCount_q <= 8'd0;
            coreRst_q     <= 1'b1;
            coreRstN_q    <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            seqState_q    <= seqState_d;
            cnt_q         <= cnt_d;
            relockCount_q <= relockCount_d;
            coreRst_q     <= (seqState_d != RUN);
            coreRstN_q    <= (seqState_d == RUN);
            ready_q       <= (seqState_d == RUN);
        end
    end

    assign core_rst     = coreRst_q;
    assign core_rst_n   = coreRstN_q;
    assign ready        = ready_q;
    assign state        = seqState_q;
    assign relock_count = relockCount_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed testbench for pll_reset_sequencer with SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4.
// Software-reset expectations follow PLL_RST_SEQ_SW_RESET_EN when it is defined.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       core_rst;
    logic       core_rst_n;
    logic       ready;
    logic [1:0] state;
    logic [7:0] relock_count;

    int vecCount;
    int errCount;

    pll_reset_sequencer #(
        .SYNC_STAGES       (2),
        .LOCK_STABLE_CYCLES(8),
        .RESET_HOLD_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .sw_reset_req(sw_reset_req),
        .core_rst    (core_rst),
        .core_rst_n  (core_rst_n),
        .ready       (ready),
        .state       (state),
        .relock_count(relock_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic lock, input logic sw);
        pll_locked   = lock;
        sw_reset_req = sw;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vecCount++;
        assert (observed === expected)
        else begin
            errCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Outputs in every state are fixed by the state: core_rst low and ready high only in RUN
    task automatic checkStatus(input string tag, input logic [1:0] expState, input logic [7:0] expRelock);
        checkOutput({tag, ".state"},      {6'd0, state},      {6'd0, expState});
        checkOutput({tag, ".core_rst"},   {7'd0, core_rst},   (expState == 2'd3) ? 8'd0 : 8'd1);
        checkOutput({tag, ".core_rst_n"}, {7'd0, core_rst_n}, (expState == 2'd3) ? 8'd1 : 8'd0);
        checkOutput({tag, ".ready"},      {7'd0, ready},      (expState == 2'd3) ? 8'd1 : 8'd0);
        checkOutput({tag, ".relock"},     relock_count,       expRelock);
    endtask

    // Lock rises before edge 1: STABLE at edge 3, HOLD at edge 11, RUN at edge 15
    task automatic runSequence(input string tag, input logic [7:0] expRelock, input int lastEdge);
        logic [1:0] expState;
        applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= lastEdge; e++) begin
            tick();
            if (e < 3)       expState = 2'd0;
            else if (e < 11) expState = 2'd1;
            else if (e < 15) expState = 2'd2;
            else             expState = 2'd3;
            checkStatus($sformatf("%s.e%0d", tag, e), expState, expRelock);
        end
    endtask

    task automatic dropFromRun(input string tag, input logic [7:0] expRelock);
        applyStimulus(1'b0, 1'b0);
        tick();
        checkStatus({tag, ".d1"}, 2'd3, expRelock - 8'd1);
        tick();
        checkStatus({tag, ".d2"}, 2'd3, expRelock - 8'd1);
        tick();
        checkStatus({tag, ".d3"}, 2'd0, expRelock);
    endtask

    initial begin
        vecCount = 0;
        errCount = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        tick();
        tick();
        checkStatus("reset", 2'd0, 8'd0);

        rst = 1'b0;
        tick();
        checkStatus("idle", 2'd0, 8'd0);

        runSequence("seq1", 8'd0, 15);
        dropFromRun("runDrop", 8'd1);

        // Lock drop sampled at edges 7..9 while in STABLE
        applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            tick();
            checkStatus($sformatf("stbl.e%0d", e), (e < 3) ? 2'd0 : 2'd1, 8'd1);
        end
        applyStimulus(1'b0, 1'b0);
        tick();
        checkStatus("stbl.e7", 2'd1, 8'd1);
        tick();
        checkStatus("stbl.e8", 2'd1, 8'd1);
        tick();
        checkStatus("stbl.e9", 2'd0, 8'd2);
        runSequence("seq2", 8'd2, 15);

        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0);
`ifdef PLL_RST_SEQ_SW_RESET_EN
        checkStatus("swr.e1", 2'd2, 8'd2);
        for (int e = 2; e <= 4; e++) begin
            tick();
            checkStatus($sformatf("swr.e%0d", e), 2'd2, 8'd2);
        end
        tick();
        checkStatus("swr.e5", 2'd3, 8'd2);
`else
        checkStatus("swr.e1", 2'd3, 8'd2);
        for (int e = 2; e <= 5; e++) begin
            tick();
            checkStatus($sformatf("swr.e%0d", e), 2'd3, 8'd2);
        end
`endif

        dropFromRun("runDrop2", 8'd3);
        runSequence("seq3", 8'd3, 12);
        #3;
        rst = 1'b1;
        #1;
        checkStatus("asyncRst", 2'd0, 8'd0);
        tick();
        checkStatus("asyncRstHeld", 2'd0, 8'd0);
        rst = 1'b0;
        runSequence("seq4", 8'd0, 15);
        dropFromRun("runDrop3", 8'd1);

        // Each toggle reaches STABLE then loses lock; the count must stick at 255
        for (int t = 1; t <= 300; t++) begin
            applyStimulus(1'b1, 1'b0);
            tick();
            tick();
            tick();
            checkOutput($sformatf("sat%0d.state", t), {6'd0, state}, 8'd1);
            applyStimulus(1'b0, 1'b0);
            tick();
            tick();
            tick();
            checkOutput($sformatf("sat%0d.relock", t), relock_count,
                        (t + 1 > 255) ? 8'd255 : 8'(t + 1));
        end
        checkStatus("satFinal", 2'd0, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
